// File: rtl/monocicle_cpu.sv
// monocicle_cpu: single-cycle RV64I-subset core with private instruction
// memory, data memory and register file. One instruction retires per rising
// edge of CLK.
//
// Ports (top):
//   CLK  in  1  system clock, all state updates on the rising edge
//   RST  in  1  asynchronous active-low reset (clears PC and registers)
//
// Fixed instance/array names used for preload and inspection:
//   PC_mono.OUT              program counter (byte address)
//   inst_mono.memory         32-bit words, indexed by PC[log2(INST_DEPTH)+1:2]
//   register_mono.registers  32 x XLEN architectural registers
//   data_mono.memory         byte array, little-endian, address wraps
//
// Optional feature: define MONOCICLE_JAL_EN to decode jal/jalr. Without it
// both opcodes behave as NOPs.
//
// INST_DEPTH and DATA_DEPTH are expected to be powers of two so that the
// address slices wrap naturally.

// Program counter register. Output name OUT is fixed for external inspection.
module monocicle_pc #(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] pc_d_i,
  output logic [XLEN-1:0] OUT
);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) OUT <= '0;
    else         OUT <= pc_d_i;
  end
endmodule

// Instruction memory: combinational word read, contents preloaded externally.
module monocicle_inst_mem #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic [AW-1:0] addr_i,
  output logic [31:0]   inst_o
);
  logic [31:0] memory [0:DEPTH-1];

  assign inst_o = memory[addr_i];
endmodule

// Register file: two combinational read ports, one synchronous write port.
// x0 is hardwired to zero on read and never written.
module monocicle_regfile #(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  input  logic [4:0]      rd_i,
  input  logic            we_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o
);
  logic [XLEN-1:0] registers [0:31];

  assign rs1_data_o = (rs1_i == 5'd0) ? '0 : registers[rs1_i];
  assign rs2_data_o = (rs2_i == 5'd0) ? '0 : registers[rs2_i];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (we_i && (rd_i != 5'd0)) begin
      registers[rd_i] <= wdata_i;
    end
  end
endmodule

// Data memory: byte array, doubleword read combinational, doubleword write
// on the rising edge. Each byte address wraps independently, so an access
// near the top of memory spills over into address 0.
module monocicle_data_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int XLEN  = 64
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] rdata_o
);
  logic [7:0] memory [0:DEPTH-1];

  always_comb begin
    rdata_o = '0;
    for (int k = 0; k < XLEN / 8; k++) begin
      rdata_o[8*k +: 8] = memory[addr_i + AW'(k)];
    end
  end

  // Not reset: contents survive RST and are preloaded from outside.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int k = 0; k < XLEN / 8; k++) begin
        memory[addr_i + AW'(k)] <= wdata_i[8*k +: 8];
      end
    end
  end
endmodule

module monocicle_cpu #(
  parameter int INST_DEPTH = 64,
  parameter int DATA_DEPTH = 256,
  parameter int XLEN       = 64
) (
  input logic CLK,
  input logic RST
);
  localparam int IAW = $clog2(INST_DEPTH);
  localparam int DAW = $clog2(DATA_DEPTH);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef MONOCICLE_JAL_EN
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
`endif

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [31:0]     inst;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rd_we;
  logic [XLEN-1:0] rd_wdata;
  logic            mem_we;
  logic [DAW-1:0]  mem_addr;
  logic [XLEN-1:0] mem_rdata;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [6:0] funct7;
  logic [5:0] funct6;
  logic [5:0] shamt;

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
`ifdef MONOCICLE_JAL_EN
  logic [XLEN-1:0] imm_j;
`endif

  monocicle_pc #(.XLEN(XLEN)) PC_mono (
    .clk_i  (CLK),
    .rst_ni (RST),
    .pc_d_i (pc_d),
    .OUT    (pc_q)
  );

  monocicle_inst_mem #(.DEPTH(INST_DEPTH), .AW(IAW)) inst_mono (
    .addr_i (pc_q[IAW+1:2]),
    .inst_o (inst)
  );

  monocicle_regfile #(.XLEN(XLEN)) register_mono (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .rs1_i      (rs1),
    .rs2_i      (rs2),
    .rd_i       (rd),
    .we_i       (rd_we),
    .wdata_i    (rd_wdata),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data)
  );

  monocicle_data_mem #(.DEPTH(DATA_DEPTH), .AW(DAW), .XLEN(XLEN)) data_mono (
    .clk_i   (CLK),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (rs2_data),
    .rdata_o (mem_rdata)
  );

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];
  assign funct6 = inst[31:26];
  assign shamt  = inst[25:20];

  assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25],
                  inst[11:8], 1'b0};
`ifdef MONOCICLE_JAL_EN
  assign imm_j = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20],
                  inst[30:21], 1'b0};
`endif

  // Stores use the S immediate, everything else the I immediate; only the
  // low DAW bits matter because the data memory wraps.
  assign mem_addr = (opcode == OP_STORE) ? DAW'(rs1_data + imm_s)
                                         : DAW'(rs1_data + imm_i);

  always_comb begin
    rd_we    = 1'b0;
    rd_wdata = '0;
    mem_we   = 1'b0;
    pc_d     = pc_q + XLEN'(4);
    case (opcode)
      OP_R: begin
        rd_we = 1'b1;
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: rd_wdata = rs1_data + rs2_data;
          {7'b0100000, 3'b000}: rd_wdata = rs1_data - rs2_data;
          {7'b0000000, 3'b001}: rd_wdata = rs1_data << rs2_data[5:0];
          {7'b0000000, 3'b010}: rd_wdata = {{(XLEN-1){1'b0}},
                                  ($signed(rs1_data) < $signed(rs2_data))};
          {7'b0000000, 3'b011}: rd_wdata = {{(XLEN-1){1'b0}}, (rs1_data < rs2_data)};
          {7'b0000000, 3'b100}: rd_wdata = rs1_data ^ rs2_data;
          {7'b0000000, 3'b101}: rd_wdata = rs1_data >> rs2_data[5:0];
          {7'b0100000, 3'b101}: rd_wdata = $signed(rs1_data) >>> rs2_data[5:0];
          {7'b0000000, 3'b110}: rd_wdata = rs1_data | rs2_data;
          {7'b0000000, 3'b111}: rd_wdata = rs1_data & rs2_data;
          default:              rd_we    = 1'b0;
        endcase
      end
      OP_IMM: begin
        rd_we = 1'b1;
        case (funct3)
          3'b000: rd_wdata = rs1_data + imm_i;
          3'b010: rd_wdata = {{(XLEN-1){1'b0}}, ($signed(rs1_data) < $signed(imm_i))};
          3'b011: rd_wdata = {{(XLEN-1){1'b0}}, (rs1_data < imm_i)};
          3'b100: rd_wdata = rs1_data ^ imm_i;
          3'b110: rd_wdata = rs1_data | imm_i;
          3'b111: rd_wdata = rs1_data & imm_i;
          3'b001: begin
            if (funct6 == 6'b000000) rd_wdata = rs1_data << shamt;
            else                     rd_we    = 1'b0;
          end
          3'b101: begin
            if (funct6 == 6'b000000)      rd_wdata = rs1_data >> shamt;
            else if (funct6 == 6'b010000) rd_wdata = $signed(rs1_data) >>> shamt;
            else                          rd_we    = 1'b0;
          end
          default: rd_we = 1'b0;
        endcase
      end
      OP_LOAD: begin
        if (funct3 == 3'b011) begin
          rd_we    = 1'b1;
          rd_wdata = mem_rdata;
        end
      end
      OP_STORE: begin
        // Gated by RST so that no write can land while reset is held.
        if (funct3 == 3'b011) mem_we = RST;
      end
      OP_BRANCH: begin
        case (funct3)
          3'b000:  if (rs1_data == rs2_data) pc_d = pc_q + imm_b;
          3'b001:  if (rs1_data != rs2_data) pc_d = pc_q + imm_b;
          3'b100:  if ($signed(rs1_data) <  $signed(rs2_data)) pc_d = pc_q + imm_b;
          3'b101:  if ($signed(rs1_data) >= $signed(rs2_data)) pc_d = pc_q + imm_b;
          default: pc_d = pc_q + XLEN'(4);
        endcase
      end
`ifdef MONOCICLE_JAL_EN
      OP_JAL: begin
        rd_we    = 1'b1;
        rd_wdata = pc_q + XLEN'(4);
        pc_d     = pc_q + imm_j;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          rd_we    = 1'b1;
          rd_wdata = pc_q + XLEN'(4);
          pc_d     = (rs1_data + imm_i) & ~XLEN'(1);
        end
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: tb/tb_monocicle_cpu.sv
module tb_monocicle_cpu;
  logic CLK;
  logic RST;

  int n_vec;
  int n_err;

  monocicle_cpu dut (
    .CLK (CLK),
    .RST (RST)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_mems();
    for (int i = 0; i < 64; i++)  dut.inst_mono.memory[i] = 32'h0;
    for (int i = 0; i < 256; i++) dut.data_mono.memory[i] = 8'h0;
  endtask

  // Enter reset between edges and wipe both memories; program loads follow.
  task automatic begin_prog();
    @(negedge CLK);
    RST = 1'b0;
    #1;
    clear_mems();
  endtask

  task automatic go(input int n);
    RST = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic logic [63:0] reg_x(input int i);
    return dut.register_mono.registers[i];
  endfunction

  function automatic logic [63:0] dword_at(input int a);
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = dut.data_mono.memory[(a + k) % 256];
    return v;
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    RST = 1'b1;
    #1 RST = 1'b0;
    #1;

    // Reset state and preload under reset
    check_vec("rst_pc",  dut.PC_mono.OUT, 64'd0);
    check_vec("rst_x1",  reg_x(1), 64'd0);
    check_vec("rst_x31", reg_x(31), 64'd0);
    clear_mems();
    dut.data_mono.memory[0] = 8'd5;
    dut.data_mono.memory[8] = 8'd7;
    dut.inst_mono.memory[0] = 32'h00003083; // ld   x1,0(x0)
    dut.inst_mono.memory[1] = 32'h00803103; // ld   x2,8(x0)
    dut.inst_mono.memory[2] = 32'h002081B3; // add  x3,x1,x2
    dut.inst_mono.memory[3] = 32'h00303823; // sd   x3,16(x0)
    step(2);
    check_vec("hold_pc",    dut.PC_mono.OUT, 64'd0);
    check_vec("hold_dmem0", dword_at(0), 64'd5);
    check_vec("hold_dmem8", dword_at(8), 64'd7);

    // ld / add / sd
    @(negedge CLK);
    go(4);
    check_vec("lds_x1",  reg_x(1), 64'd5);
    check_vec("lds_x3",  reg_x(3), 64'd12);
    check_vec("lds_m16", dword_at(16), 64'd12);
    check_vec("lds_b16", {56'd0, dut.data_mono.memory[16]}, 64'h0C);
    check_vec("lds_pc",  dut.PC_mono.OUT, 64'd16);

    // sub negative, write to x0 discarded
    begin_prog();
    dut.inst_mono.memory[0] = 32'h00300093; // addi x1,x0,3
    dut.inst_mono.memory[1] = 32'h40100133; // sub  x2,x0,x1
    dut.inst_mono.memory[2] = 32'h00900013; // addi x0,x0,9
    go(3);
    check_vec("sub_x2", reg_x(2), 64'hFFFFFFFFFFFFFFFD);
    check_vec("sub_x0", reg_x(0), 64'd0);
    check_vec("sub_pc", dut.PC_mono.OUT, 64'd12);

    // bne countdown loop
    begin_prog();
    dut.inst_mono.memory[0] = 32'h00500093; // addi x1,x0,5
    dut.inst_mono.memory[1] = 32'hFFF08093; // addi x1,x1,-1
    dut.inst_mono.memory[2] = 32'hFE009EE3; // bne  x1,x0,-4
    go(3);
    check_vec("loop3_pc", dut.PC_mono.OUT, 64'd4);
    check_vec("loop3_x1", reg_x(1), 64'd4);
    step(8);
    check_vec("loop_pc", dut.PC_mono.OUT, 64'd12);
    check_vec("loop_x1", reg_x(1), 64'd0);

    // beq not taken then taken
    begin_prog();
    dut.inst_mono.memory[0] = 32'h00100093; // addi x1,x0,1
    dut.inst_mono.memory[1] = 32'h00008463; // beq  x1,x0,8 (not taken)
    dut.inst_mono.memory[2] = 32'h00000463; // beq  x0,x0,8 (taken)
    go(2);
    check_vec("beqnt_pc", dut.PC_mono.OUT, 64'd8);
    step(1);
    check_vec("beqt_pc", dut.PC_mono.OUT, 64'd16);

    // srai / sltu / slt on a negative operand
    begin_prog();
    dut.inst_mono.memory[0] = 32'hFF800093; // addi x1,x0,-8
    dut.inst_mono.memory[1] = 32'h4010D113; // srai x2,x1,1
    dut.inst_mono.memory[2] = 32'h001031B3; // sltu x3,x0,x1
    dut.inst_mono.memory[3] = 32'h0000A233; // slt  x4,x1,x0
    go(4);
    check_vec("srai_x2", reg_x(2), 64'hFFFFFFFFFFFFFFFC);
    check_vec("sltu_x3", reg_x(3), 64'd1);
    check_vec("slt_x4",  reg_x(4), 64'd1);

    // Top-of-memory store/load and byte-wise wrap
    begin_prog();
    dut.inst_mono.memory[0] = 32'h0F800093; // addi x1,x0,248
    dut.inst_mono.memory[1] = 32'hFFD00113; // addi x2,x0,-3
    dut.inst_mono.memory[2] = 32'h0020B023; // sd   x2,0(x1)
    dut.inst_mono.memory[3] = 32'h0000B183; // ld   x3,0(x1)
    dut.inst_mono.memory[4] = 32'h0020B223; // sd   x2,4(x1)  -> 252..3
    dut.inst_mono.memory[5] = 32'h0040B203; // ld   x4,4(x1)
    go(6);
    check_vec("wrap_x3", reg_x(3), 64'hFFFFFFFFFFFFFFFD);
    check_vec("wrap_x4", reg_x(4), 64'hFFFFFFFFFFFFFFFD);
    check_vec("wrap_b0", {56'd0, dut.data_mono.memory[0]}, 64'hFF);
    check_vec("wrap_b252", {56'd0, dut.data_mono.memory[252]}, 64'hFD);
    check_vec("wrap_b4", {56'd0, dut.data_mono.memory[4]}, 64'h00);

    // Asynchronous reset between edges
    #1 RST = 1'b0;
    #1;
    check_vec("arst_pc", dut.PC_mono.OUT, 64'd0);
    check_vec("arst_x3", reg_x(3), 64'd0);
    check_vec("arst_b248", {56'd0, dut.data_mono.memory[248]}, 64'hFD);

    // jal / jalr
    begin_prog();
    dut.inst_mono.memory[0] = 32'h008000EF; // jal  x1,8
    dut.inst_mono.memory[2] = 32'h00108167; // jalr x2,1(x1)
    go(1);
`ifdef MONOCICLE_JAL_EN
    check_vec("jal_pc", dut.PC_mono.OUT, 64'd8);
    check_vec("jal_x1", reg_x(1), 64'd4);
    step(1);
    check_vec("jalr_pc", dut.PC_mono.OUT, 64'd4);
    check_vec("jalr_x2", reg_x(2), 64'd12);
`else
    check_vec("jal_pc", dut.PC_mono.OUT, 64'd4);
    check_vec("jal_x1", reg_x(1), 64'd0);
    step(1);
    check_vec("jalr_pc", dut.PC_mono.OUT, 64'd8);
    check_vec("jalr_x2", reg_x(2), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
